// File: rtl/csa_serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csa_serial_add_ctrl_pkg
// Purpose  : Shared definitions for the serial carry-select add/sub
//            controller: default operand width and controller state encoding.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package csa_serial_add_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 16;

   // State encodings, shared by the controller and anyone decoding its state.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage
`default_nettype wire

// File: rtl/csa_serial_add_ctrl_csa_2.sv
`default_nettype none
// ============================================================================
// Module   : CSA_2
// Purpose  : 2-bit carry-select adder slice. Bit 0 is a plain full adder;
//            bit 1 is precomputed for both possible carries and selected by
//            the carry out of bit 0.
// Ports    : a[1:0], b[1:0]  - operand bit pairs
//            cin             - carry into bit 0
//            sum[1:0]        - slice sum
//            cout            - carry out of bit 1
//            second_out      - carry into bit 1 (used for signed overflow)
// Revision : 1.0 - initial release
// ============================================================================
module CSA_2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic       cout,
   output logic [1:0] sum,
   output logic       second_out
);

   logic c1;
   logic s1_c0;
   logic s1_c1;
   logic c2_c0;
   logic c2_c1;

   assign c1 = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));

   // Upper bit evaluated for both carry-in values, then selected by c1.
   assign s1_c0 = a[1] ^ b[1];
   assign s1_c1 = ~(a[1] ^ b[1]);
   assign c2_c0 = a[1] & b[1];
   assign c2_c1 = a[1] | b[1];

   assign sum[0]     = a[0] ^ b[0] ^ cin;
   assign sum[1]     = c1 ? s1_c1 : s1_c0;
   assign cout       = c1 ? c2_c1 : c2_c0;
   assign second_out = c1;

endmodule
`default_nettype wire

// File: rtl/csa_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csa_serial_add_ctrl
// Purpose  : Multi-cycle add/subtract controller. Processes WIDTH-bit operands
//            two bits per clock through a single CSA_2 slice, LSB pair first,
//            with the inter-slice carry held in a register.
// Ports    : clk, rst (async, active-high)
//            in_valid / in_ready   - operand handshake (a, b, sub)
//            flush                 - synchronous abort to IDLE
//            out_valid / out_ready - result handshake (sum, cout, overflow)
//            busy                  - high while computing
// Revision : 1.0 - initial release
// ============================================================================
module csa_serial_add_ctrl
   import csa_serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             cout_reg;
   logic             overflow_reg;

   logic             load;
   logic             shift;
   logic             last;

   logic [1:0]       slice_sum;
   logic             slice_cout;
   logic             slice_second;

   CSA_2 u_slice (
      .a          (a_reg[1:0]),
      .b          (b_reg[1:0]),
      .cin        (carry),
      .cout       (slice_cout),
      .sum        (slice_sum),
      .second_out (slice_second)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
      last       = 1'b0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy  = 1'b1;
            shift = 1'b1;
            if (cnt == LAST_CNT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort overrides every transition, including an accept in IDLE.
      if (flush) begin
         state_next = IDLE;
         load       = 1'b0;
         shift      = 1'b0;
         last       = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Datapath: operand shift registers, result shift-in, carry chain
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         sum_reg      <= '0;
         carry        <= 1'b0;
         cnt          <= '0;
         cout_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (flush) begin
         // Result registers intentionally keep their stale contents.
         cnt <= '0;
      end else if (load) begin
         // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
         a_reg <= a;
         b_reg <= sub ? ~b : b;
         carry <= sub;
         cnt   <= '0;
      end else if (shift) begin
         sum_reg <= {slice_sum, sum_reg[WIDTH-1:2]};
         a_reg   <= {2'b00, a_reg[WIDTH-1:2]};
         b_reg   <= {2'b00, b_reg[WIDTH-1:2]};
         carry   <= slice_cout;
         cnt     <= cnt + 1'b1;
         if (last) begin
            // On the final pair, second_out is the carry into bit WIDTH-1.
            cout_reg     <= slice_cout;
            overflow_reg <= slice_second ^ slice_cout;
         end
      end
   end

   assign sum      = sum_reg;
   assign cout     = cout_reg;
   assign overflow = overflow_reg;

endmodule
`default_nettype wire

// File: tb/tb_csa_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_serial_add_ctrl
// Purpose  : Self-checking bench for csa_serial_add_ctrl (WIDTH=16):
//            directed vectors with hand-computed results, backpressure,
//            reset/flush abort, and a randomised add/sub run against an
//            independent arithmetic model.
// Ports    : (none)
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_serial_add_ctrl;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             busy;

   int checks;
   int errors;

   csa_serial_add_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns {overflow, cout, sum} computed from plain integer arithmetic.
   function automatic logic [17:0] ref_model(input logic [15:0] op_a,
                                             input logic [15:0] op_b,
                                             input logic op_sub);
      logic [16:0] full;
      logic        ovf;
      if (op_sub) begin
         full = {1'b0, op_a} + {1'b0, ~op_b} + 17'd1;
         ovf  = (op_a[15] != op_b[15]) && (full[15] != op_a[15]);
      end else begin
         full = {1'b0, op_a} + {1'b0, op_b};
         ovf  = (op_a[15] == op_b[15]) && (full[15] != op_a[15]);
      end
      return {ovf, full[16], full[15:0]};
   endfunction

   // Entered and left 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_result(input string tag);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_val({tag, " latency"}, n, 8);
   endtask

   task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic op_sub, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf,
                         input int rdy_delay, input bit noisy,
                         input string tag);
      check_val({tag, " in_ready"}, in_ready, 1);
      a        = op_a;
      b        = op_b;
      sub      = op_sub;
      in_valid = 1'b1;
      tick();
      // Scramble inputs after the accept edge; they must be ignored.
      in_valid = noisy ? 1'($urandom) : 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
      sub      = 1'($urandom);
      wait_result(tag);
      repeat (rdy_delay) tick();
      check_val({tag, " sum"}, sum, exp_sum);
      check_val({tag, " cout"}, cout, exp_cout);
      check_val({tag, " ovf"}, overflow, exp_ovf);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_val({tag, " ov_drop"}, out_valid, 0);
   endtask

   initial begin
      logic [17:0] exp;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      int          seen;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;

      repeat (2) tick();
      check_val("rst in_ready", in_ready, 1);
      check_val("rst out_valid", out_valid, 0);
      check_val("rst busy", busy, 0);
      check_val("rst sum", sum, 0);
      check_val("rst cout", cout, 0);
      check_val("rst ovf", overflow, 0);
      rst = 1'b0;
      tick();

      // Directed arithmetic vectors
      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 0, "add1");
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0, "addwrap");
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 0, "addovf");
      run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0, 0, "subneg");
      run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 2, 0, "subovf");

      // Backpressure: result held, new operands waiting, no accept
      a = 16'h00FF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_result("bp");
      a = 16'h0003; b = 16'h0004; sub = 1'b0; in_valid = 1'b1;
      seen = 0;
      repeat (5) begin
         tick();
         if (out_valid !== 1'b1 || sum !== 16'h0100 || in_ready !== 1'b0
             || busy !== 1'b0) seen++;
      end
      check_val("bp hold", seen, 0);
      check_val("bp sum", sum, 16'h0100);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_val("bp idle", in_ready, 1);
      check_val("bp idle busy", busy, 0);
      tick();
      in_valid = 1'b0;
      check_val("bp accept", busy, 1);
      wait_result("bp2");
      check_val("bp2 sum", sum, 16'h0007);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Asynchronous reset mid-RUN
      a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check_val("arst busy", busy, 0);
      check_val("arst out_valid", out_valid, 0);
      check_val("arst in_ready", in_ready, 1);
      check_val("arst sum", sum, 0);
      #2 rst = 1'b0;
      tick();

      // Flush mid-RUN
      a = 16'h1234; b = 16'h4321; sub = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_val("flush busy", busy, 0);
      check_val("flush in_ready", in_ready, 1);
      seen = 0;
      repeat (10) begin
         tick();
         if (out_valid !== 1'b0) seen++;
      end
      check_val("flush no ov", seen, 0);

      // Flush with in_valid in IDLE: no accept
      a = 16'h0001; b = 16'h0001; in_valid = 1'b1; flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      check_val("flush idle", busy, 0);
      check_val("flush idle rdy", in_ready, 1);

      run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 0, "post");

      // Random back-to-back operations against the model
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rs  = 1'($urandom);
         exp = ref_model(ra, rb, rs);
         run_op(ra, rb, rs, exp[15:0], exp[16], exp[17],
                $urandom_range(0, 3), 1, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
